// File: rtl/mips_pkg.sv
// Shared MIPS decode constants, the issue-stage decode bundle,
// and the operand forwarding helper.
package mips_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_ADDU = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SUBU = 4'b1110;
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_XOR  = 4'b1100;
    localparam logic [3:0] ALU_NOR  = 4'b1010;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_LUI  = 4'b1111;
    localparam logic [3:0] ALU_JAL  = 4'b0100;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLTU = 6'b101011;

    localparam logic [4:0] RA = 5'd31;

    typedef enum logic {EXT_SIGN, EXT_ZERO} ext_e;
    typedef enum logic [1:0] {A_RS, A_RT, A_PC8} a_sel_e;
    typedef enum logic [1:0] {B_RT, B_IMM, B_ZERO} b_sel_e;
    typedef enum logic [1:0] {RD_RD, RD_RT, RD_RA} rd_sel_e;

    typedef struct packed {
        logic [3:0] aluc;
        ext_e       ext;
        a_sel_e     a_sel;
        b_sel_e     b_sel;
        rd_sel_e    rd_sel;
        logic       wen;
        logic       ill;
    } dec_t;

    // EX/MEM result is younger than MEM/WB, so it wins on a tie.
    function automatic logic [31:0] fwd(
        input logic [4:0]  idx,
        input logic [31:0] rf,
        input logic        mwen,
        input logic [4:0]  mrd,
        input logic [31:0] mdata,
        input logic        wwen,
        input logic [4:0]  wrd,
        input logic [31:0] wdata
    );
        if (idx == 5'd0)
            return 32'd0;
        else if (mwen && mrd == idx)
            return mdata;
        else if (wwen && wrd == idx)
            return wdata;
        else
            return rf;
    endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational decode of opcode/funct into ALU code and
// operand, destination and write-enable selects.
module alu_ctrl_dec
    import mips_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output dec_t       dec
);

    always_comb begin
        dec.aluc   = ALU_AND;
        dec.ext    = EXT_SIGN;
        dec.a_sel  = A_RS;
        dec.b_sel  = B_IMM;
        dec.rd_sel = RD_RT;
        dec.wen    = 1'b1;
        dec.ill    = 1'b0;
        case (op)
            OP_RTYPE: begin
                dec.rd_sel = RD_RD;
                dec.b_sel  = B_RT;
                case (funct)
                    F_ADD:  dec.aluc = ALU_ADD;
                    F_ADDU: dec.aluc = ALU_ADDU;
                    F_SUB:  dec.aluc = ALU_SUB;
                    F_SUBU: dec.aluc = ALU_SUBU;
                    F_AND:  dec.aluc = ALU_AND;
                    F_OR:   dec.aluc = ALU_OR;
                    F_XOR:  dec.aluc = ALU_XOR;
                    F_NOR:  dec.aluc = ALU_NOR;
                    F_SLT:  dec.aluc = ALU_SLT;
                    F_SLTU: dec.aluc = ALU_SLTU;
                    F_SLL, F_SRL: begin
                        // shamt rides in the sign-extended imm field
                        dec.aluc  = (funct == F_SLL) ? ALU_SLL : ALU_SRL;
                        dec.a_sel = A_RT;
                        dec.b_sel = B_IMM;
                    end
                    default: begin
                        dec.ill = 1'b1;
                        dec.wen = 1'b0;
                    end
                endcase
            end
            OP_ADDI:  dec.aluc = ALU_ADD;
            OP_ADDIU: dec.aluc = ALU_ADDU;
            OP_SLTI:  dec.aluc = ALU_SLT;
            OP_SLTIU: dec.aluc = ALU_SLTU;
            OP_ANDI: begin
                dec.aluc = ALU_AND;
                dec.ext  = EXT_ZERO;
            end
            OP_ORI: begin
                dec.aluc = ALU_OR;
                dec.ext  = EXT_ZERO;
            end
            OP_XORI: begin
                dec.aluc = ALU_XOR;
                dec.ext  = EXT_ZERO;
            end
            OP_LUI: begin
                dec.aluc = ALU_LUI;
                dec.ext  = EXT_ZERO;
            end
            OP_LW: dec.aluc = ALU_ADD;
            OP_SW: begin
                dec.aluc = ALU_ADD;
                dec.wen  = 1'b0;
            end
            OP_BEQ, OP_BNE: begin
                dec.aluc  = ALU_SUB;
                dec.b_sel = B_RT;
                dec.wen   = 1'b0;
            end
            OP_JAL: begin
                dec.aluc   = ALU_JAL;
                dec.a_sel  = A_PC8;
                dec.b_sel  = B_ZERO;
                dec.rd_sel = RD_RA;
            end
            default: begin
                dec.ill = 1'b1;
                dec.wen = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/idex_issue.sv
// ID/EX issue stage: decode, operand forwarding and the
// ID/EX pipeline register behind a valid/ready handshake.
module idex_issue
    import mips_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] DINSTR,
    input  logic [31:0] DPC4,
    input  logic [31:0] DA,
    input  logic [31:0] DB,
    input  logic        DVALID,
    output logic        DREADY,
    input  logic        MWEN,
    input  logic [4:0]  MRD,
    input  logic [31:0] MDATA,
    input  logic        WWEN,
    input  logic [4:0]  WRD,
    input  logic [31:0] WDATA,
    input  logic        FLUSH,
    input  logic        EREADY,
    output logic        EVALID,
    output logic [3:0]  EALUC,
    output logic [31:0] EXA,
    output logic [31:0] EXB,
    output logic [4:0]  ERD,
    output logic        EWEN,
    output logic        EILL
);

    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [31:0] imm_ext, rs_val, rt_val, op_a, op_b;
    logic [4:0]  dst;
    logic        accept;
    dec_t        dec;

    logic        evalid_q, evalid_d;
    logic [3:0]  ealuc_q, ealuc_d;
    logic [31:0] exa_q, exa_d;
    logic [31:0] exb_q, exb_d;
    logic [4:0]  erd_q, erd_d;
    logic        ewen_q, ewen_d;
    logic        eill_q, eill_d;

    assign rs  = DINSTR[25:21];
    assign rt  = DINSTR[20:16];
    assign rd  = DINSTR[15:11];
    assign imm = DINSTR[15:0];

    alu_ctrl_dec u_dec (
        .op    (DINSTR[31:26]),
        .funct (DINSTR[5:0]),
        .dec   (dec)
    );

    always_comb begin
        rs_val  = fwd(rs, DA, MWEN, MRD, MDATA, WWEN, WRD, WDATA);
        rt_val  = fwd(rt, DB, MWEN, MRD, MDATA, WWEN, WRD, WDATA);
        imm_ext = (dec.ext == EXT_ZERO) ? {16'd0, imm}
                                        : {{16{imm[15]}}, imm};
        case (dec.a_sel)
            A_RS:    op_a = rs_val;
            A_RT:    op_a = rt_val;
            A_PC8:   op_a = DPC4 + 32'd4;
            default: op_a = 32'd0;
        endcase
        case (dec.b_sel)
            B_RT:    op_b = rt_val;
            B_IMM:   op_b = imm_ext;
            default: op_b = 32'd0;
        endcase
        case (dec.rd_sel)
            RD_RD:   dst = rd;
            RD_RT:   dst = rt;
            RD_RA:   dst = RA;
            default: dst = 5'd0;
        endcase
        if (!dec.wen)
            dst = 5'd0;
    end

    assign DREADY = !evalid_q || EREADY;
    assign accept = DVALID && DREADY;

    always_comb begin
        evalid_d = evalid_q;
        ealuc_d  = ealuc_q;
        exa_d    = exa_q;
        exb_d    = exb_q;
        erd_d    = erd_q;
        ewen_d   = ewen_q;
        eill_d   = 1'b0;
        if (FLUSH) begin
            evalid_d = 1'b0;
            ewen_d   = 1'b0;
            erd_d    = 5'd0;
        end else if (accept && dec.ill) begin
            evalid_d = 1'b0;
            ewen_d   = 1'b0;
            erd_d    = 5'd0;
            eill_d   = 1'b1;
        end else if (accept) begin
            evalid_d = 1'b1;
            ealuc_d  = dec.aluc;
            exa_d    = op_a;
            exb_d    = op_b;
            erd_d    = dst;
            ewen_d   = dec.wen;
        end else if (DREADY) begin
            evalid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            evalid_q <= 1'b0;
            ealuc_q  <= 4'd0;
            exa_q    <= 32'd0;
            exb_q    <= 32'd0;
            erd_q    <= 5'd0;
            ewen_q   <= 1'b0;
            eill_q   <= 1'b0;
        end else begin
            evalid_q <= evalid_d;
            ealuc_q  <= ealuc_d;
            exa_q    <= exa_d;
            exb_q    <= exb_d;
            erd_q    <= erd_d;
            ewen_q   <= ewen_d;
            eill_q   <= eill_d;
        end
    end

    assign EVALID = evalid_q;
    assign EALUC  = ealuc_q;
    assign EXA    = exa_q;
    assign EXB    = exb_q;
    assign ERD    = erd_q;
    assign EWEN   = ewen_q;
    assign EILL   = eill_q;

endmodule

// File: tb/tb_idex_issue.sv
// Self-checking bench for idex_issue: vector table through a
// scoreboard queue, then hand-written stall/flush/illegal/reset cases.
module tb_idex_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] dinstr, dpc4, da, db, mdata, wdata;
    logic        dvalid, mwen, wwen, flush, eready;
    logic [4:0]  mrd, wrd;
    logic        dready, evalid, ewen, eill;
    logic [3:0]  ealuc;
    logic [31:0] exa, exb;
    logic [4:0]  erd;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] instr, pc4, da, db;
        logic        mwen;
        logic [4:0]  mrd;
        logic [31:0] mdata;
        logic        wwen;
        logic [4:0]  wrd;
        logic [31:0] wdata;
        logic [3:0]  aluc;
        logic [31:0] a, b;
        logic [4:0]  rd;
        logic        wen;
    } vec_t;

    vec_t vt[$];
    vec_t sb[$];

    always #5 clk = ~clk;

    idex_issue dut (
        .CLK(clk), .RST(rst), .DINSTR(dinstr), .DPC4(dpc4),
        .DA(da), .DB(db), .DVALID(dvalid), .DREADY(dready),
        .MWEN(mwen), .MRD(mrd), .MDATA(mdata),
        .WWEN(wwen), .WRD(wrd), .WDATA(wdata),
        .FLUSH(flush), .EREADY(eready), .EVALID(evalid),
        .EALUC(ealuc), .EXA(exa), .EXB(exb), .ERD(erd),
        .EWEN(ewen), .EILL(eill)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_entry(input string tag, input vec_t e);
        chk({tag, " evalid"}, 32'(evalid), 32'd1);
        chk({tag, " ealuc"}, 32'(ealuc), 32'(e.aluc));
        chk({tag, " exa"}, exa, e.a);
        chk({tag, " exb"}, exb, e.b);
        chk({tag, " erd"}, 32'(erd), 32'(e.rd));
        chk({tag, " ewen"}, 32'(ewen), 32'(e.wen));
        chk({tag, " eill"}, 32'(eill), 32'd0);
    endtask

    task automatic drive(input vec_t v);
        dinstr = v.instr; dpc4 = v.pc4; da = v.da; db = v.db;
        mwen = v.mwen; mrd = v.mrd; mdata = v.mdata;
        wwen = v.wwen; wrd = v.wrd; wdata = v.wdata;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " evalid"}, 32'(evalid), 32'd0);
        chk({tag, " ealuc"}, 32'(ealuc), 32'd0);
        chk({tag, " exa"}, exa, 32'd0);
        chk({tag, " exb"}, exb, 32'd0);
        chk({tag, " erd"}, 32'(erd), 32'd0);
        chk({tag, " ewen"}, 32'(ewen), 32'd0);
        chk({tag, " eill"}, 32'(eill), 32'd0);
        chk({tag, " dready"}, 32'(dready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t e, va, vb;
        // instr, pc4, da, db, mwen,mrd,mdata, wwen,wrd,wdata, aluc, a, b, rd, wen
        vt.push_back('{32'h00221820, 32'h0, 32'd5, 32'd7, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,
                       4'b0010, 32'd5, 32'd7, 5'd3, 1'b1});
        vt.push_back('{32'h00011100, 32'h0, 32'd9, 32'd1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,
                       4'b1000, 32'd1, 32'h00001100, 5'd2, 1'b1});
        vt.push_back('{32'h3404FFFF, 32'h0, 32'h55, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,
                       4'b0001, 32'd0, 32'h0000FFFF, 5'd4, 1'b1});
        vt.push_back('{32'h3C041234, 32'h0, 32'h55, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,
                       4'b1111, 32'd0, 32'h00001234, 5'd4, 1'b1});
        vt.push_back('{32'h2025FFFF, 32'h0, 32'd10, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,
                       4'b0010, 32'd10, 32'hFFFFFFFF, 5'd5, 1'b1});
        vt.push_back('{32'h00221820, 32'h0, 32'd5, 32'd7, 1'b1, 5'd1, 32'd9, 1'b1, 5'd1, 32'd4,
                       4'b0010, 32'd9, 32'd7, 5'd3, 1'b1});
        vt.push_back('{32'h00221820, 32'h0, 32'd5, 32'd7, 1'b0, 5'd1, 32'd9, 1'b1, 5'd1, 32'd4,
                       4'b0010, 32'd4, 32'd7, 5'd3, 1'b1});
        vt.push_back('{32'h00021820, 32'h0, 32'd5, 32'd7, 1'b1, 5'd0, 32'd9, 1'b0, 5'd0, 32'd0,
                       4'b0010, 32'd0, 32'd7, 5'd3, 1'b1});
        vt.push_back('{32'hAC220008, 32'h0, 32'd100, 32'd3, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,
                       4'b0010, 32'd100, 32'd8, 5'd0, 1'b0});
        vt.push_back('{32'h10220004, 32'h0, 32'd3, 32'd3, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,
                       4'b0110, 32'd3, 32'd3, 5'd0, 1'b0});
        vt.push_back('{32'h0C000010, 32'h100, 32'd3, 32'd3, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,
                       4'b0100, 32'h104, 32'd0, 5'd31, 1'b1});
        vt.push_back('{32'h0022302B, 32'h0, 32'd1, 32'd2, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,
                       4'b0101, 32'd1, 32'd2, 5'd6, 1'b1});
        vt.push_back('{32'h00223827, 32'h0, 32'd1, 32'd2, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,
                       4'b1010, 32'd1, 32'd2, 5'd7, 1'b1});
        vt.push_back('{32'h000110C2, 32'h0, 32'd6, 32'h80, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,
                       4'b1001, 32'h80, 32'h000010C2, 5'd2, 1'b1});
        vt.push_back('{32'h38288000, 32'h0, 32'd1, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,
                       4'b1100, 32'd1, 32'h00008000, 5'd8, 1'b1});
        vt.push_back('{32'h8C29FFFC, 32'h0, 32'h40, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,
                       4'b0010, 32'h40, 32'hFFFFFFFC, 5'd9, 1'b1});
        vt.push_back('{32'h00221820, 32'h0, 32'd5, 32'd7, 1'b1, 5'd5, 32'd9, 1'b1, 5'd2, 32'h77,
                       4'b0010, 32'd5, 32'h77, 5'd3, 1'b1});

        rst = 1'b1; dinstr = 0; dpc4 = 0; da = 0; db = 0; dvalid = 0;
        mwen = 0; mrd = 0; mdata = 0; wwen = 0; wrd = 0; wdata = 0;
        flush = 0; eready = 1;
        #1 chk_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // table vectors streamed back-to-back through the scoreboard
        foreach (vt[i]) begin
            @(negedge clk);
            drive(vt[i]);
            dvalid = 1'b1;
            sb.push_back(vt[i]);
            @(posedge clk); #1;
            if (evalid === 1'b1 && sb.size() > 0) begin
                e = sb.pop_front();
                chk_entry($sformatf("vec%0d", i), e);
            end else begin
                chk($sformatf("vec%0d issued", i), 32'(evalid), 32'd1);
            end
        end
        chk("sb drained", 32'(sb.size()), 32'd0);

        // idle cycle: EVALID drops, data holds
        @(negedge clk); dvalid = 1'b0;
        @(posedge clk); #1;
        chk("idle evalid", 32'(evalid), 32'd0);
        chk("idle exb hold", exb, 32'h77);

        // stall: A loaded with EREADY low, B waits three cycles
        va = vt[0]; vb = vt[13];
        @(negedge clk); drive(va); dvalid = 1'b1; eready = 1'b0;
        @(posedge clk); #1;
        chk_entry("stallA", va);
        @(negedge clk); drive(vb);
        for (int c = 0; c < 3; c++) begin
            #1 chk($sformatf("stall%0d dready", c), 32'(dready), 32'd0);
            @(posedge clk); #1;
            chk_entry($sformatf("stall%0d", c), va);
            @(negedge clk); mdata = 32'hDEAD; mwen = 1'b1; mrd = 5'd1;
        end
        drive(vb); eready = 1'b1;
        #1 chk("release dready", 32'(dready), 32'd1);
        @(posedge clk); #1;
        chk_entry("stallB", vb);
        @(negedge clk); dvalid = 1'b0;
        @(posedge clk); #1;
        chk("B once", 32'(evalid), 32'd0);

        // illegal opcode and illegal funct
        @(negedge clk); dinstr = 32'hFC000000; dvalid = 1'b1;
        @(posedge clk); #1;
        chk("ill op eill", 32'(eill), 32'd1);
        chk("ill op evalid", 32'(evalid), 32'd0);
        @(negedge clk); dvalid = 1'b0;
        @(posedge clk); #1;
        chk("ill op pulse", 32'(eill), 32'd0);
        @(negedge clk); dinstr = 32'h0000003F; dvalid = 1'b1;
        @(posedge clk); #1;
        chk("ill fn eill", 32'(eill), 32'd1);
        chk("ill fn evalid", 32'(evalid), 32'd0);
        @(negedge clk); dvalid = 1'b0;
        @(posedge clk); #1;
        chk("ill fn pulse", 32'(eill), 32'd0);

        // flush during a stall drops both entries
        @(negedge clk); drive(va); dvalid = 1'b1; eready = 1'b0;
        @(posedge clk); #1;
        chk("flushA evalid", 32'(evalid), 32'd1);
        @(negedge clk); drive(vb); flush = 1'b1;
        #1 chk("flush dready", 32'(dready), 32'd0);
        @(posedge clk); #1;
        chk("flush evalid", 32'(evalid), 32'd0);
        chk("flush ewen", 32'(ewen), 32'd0);
        chk("flush eill", 32'(eill), 32'd0);
        @(negedge clk); flush = 1'b0; dvalid = 1'b0;
        @(posedge clk); #1;
        chk("flush dropped", 32'(evalid), 32'd0);

        // asynchronous reset mid-stall
        @(negedge clk); drive(vt[10]); dvalid = 1'b1; eready = 1'b0;
        @(posedge clk); #1;
        chk("rstA erd", 32'(erd), 32'd31);
        @(negedge clk); #2 rst = 1'b1;
        #1 chk_zero("async rst");
        @(negedge clk); rst = 1'b0; dvalid = 1'b0; eready = 1'b1;
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
